ifetch: RTL and testbench
=========================

IFETCH -- requirements
Module: ifetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port npc_op, input, 2, next-PC select of the retiring instruction: 00 PC+4, 01 branch, 10 JAL, 11 JALR.
REQ-005 SHALL have port imm, input, 32, the sign-extended immediate of the retiring instruction from the immediate generator.
REQ-006 SHALL have port rs1, input, 32, the register-file rs1 value, used by JALR.
REQ-007 SHALL have port br_taken, input, 1, the branch condition result, used when npc_op=01.
REQ-008 SHALL have port imem_req, output, 1, the instruction-memory read request.
REQ-009 SHALL have port imem_addr, output, 32, the fetch address, equal to pc.
REQ-010 SHALL have port imem_ack, input, 1, a one-cycle pulse marking imem_rdata valid.
REQ-011 SHALL have port imem_rdata, input, 32, the fetched instruction word.
REQ-012 SHALL have port inst, output, 32, the registered instruction to decode.
REQ-013 SHALL have port inst_valid, output, 1, high while inst holds an unretired instruction.
REQ-014 SHALL have port inst_ready, input, 1, downstream retires inst this cycle.
REQ-015 SHALL have port pc, output, 32, the address of inst.
REQ-016 SHALL have port pc4, output, 32, pc+4 for link writeback.
REQ-017 SHALL have port fetch_err, output, 1, sticky misaligned-target flag.

Function
REQ-018 SHALL implement FSM states IDLE, FETCH, VALID, HALT.
REQ-019 SHALL transition IDLE->FETCH unconditionally on the first clock edge after reset is released.
REQ-020 SHALL drive imem_req=1 only in FETCH, with imem_addr held equal to pc for the whole request.
REQ-021 SHALL, in FETCH with imem_ack=1, capture imem_rdata into inst, set inst_valid=1 and enter VALID on the same edge.
REQ-022 SHALL ignore imem_ack in any state other than FETCH.
REQ-023 SHALL hold inst, pc and inst_valid unchanged in VALID while inst_ready=0.
REQ-024 SHALL, in VALID with inst_ready=1, load pc with npc, clear inst_valid and enter FETCH on the same edge, giving a minimum of 2 cycles per instruction.
REQ-025 SHALL compute npc as: 00 -> pc+4; 01 -> pc+imm if br_taken=1, else pc+4; 10 -> pc+imm; 11 -> (rs1+imm) with bit 0 cleared.
REQ-026 SHALL compute all address arithmetic in 32 bits, modulo 2^32 (for example, pc=32'hFFFF_FFFC with op 00 gives npc=0).
REQ-027 SHALL sample npc_op, imm, rs1 and br_taken only on the retiring edge.
REQ-028 SHALL drive pc4 combinationally as pc+4.
REQ-029 SHALL in HALT drive imem_req=0 and inst_valid=0, and leave HALT only through reset.

Reset
REQ-030 SHALL, while rst=1, asynchronously force state=IDLE, pc=RESET_PC, inst=0, inst_valid=0, imem_req=0, fetch_err=0.
REQ-031 SHALL abandon an outstanding fetch when reset is asserted mid-request; a later imem_ack arriving in IDLE is ignored.

Configuration
REQ-032 SHALL, when MISALIGN_CHK_EN is defined, on a retiring edge with npc[1:0]!=0: leave pc unchanged, set fetch_err=1, clear inst_valid and enter HALT.
REQ-033 SHALL, when MISALIGN_CHK_EN is undefined, tie fetch_err to 0 and load npc unaltered, with its low bits passed to imem_addr.

Verification
REQ-034 SHALL cover reset release with RESET_PC=0 and immediate ack -> imem_req in cycle 1 with addr 0; inst_valid=1 in cycle 2 with inst=rdata.
REQ-035 SHALL cover a retire at pc=0x100 with npc_op=01, imm=-8 (32'hFFFF_FFF8), br_taken=1 -> next imem_addr=0xF8; with br_taken=0 -> next imem_addr=0x104.
REQ-036 SHALL cover a JALR with rs1=0x2001, imm=4 -> next imem_addr=0x2004; pc4 before retire equals pc+4.
REQ-037 SHALL cover inst_ready held at 0 for 5 cycles in VALID -> inst, pc and inst_valid stable with imem_req=0; a spurious imem_ack during that window changes nothing.
REQ-038 SHALL cover rst pulsed while imem_req=1 at pc=0x40 -> immediate pc=RESET_PC and imem_req=0; a late ack is ignored.
REQ-039 SHALL, with MISALIGN_CHK_EN defined, cover a JAL at pc=0x10 with imm=6 -> fetch_err=1, HALT entered, pc stays 0x10, and no further imem_req.

Source files
------------

// File: rtl/ifetch.sv
// Instruction fetch unit: one outstanding imem read, holds the fetched word until retired, then steers pc to npc.
// Optional MISALIGN_CHK_EN halts on a misaligned next-PC and raises the sticky fetch_err.
module ifetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  npc_op,
    input  logic [31:0] imm,
    input  logic [31:0] rs1,
    input  logic        br_taken,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] pc,
    output logic [31:0] pc4,
    output logic        fetch_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        VALID = 2'd2,
        HALT  = 2'd3
    } state_t;

    localparam logic [1:0] OP_SEQ  = 2'b00;
    localparam logic [1:0] OP_BR   = 2'b01;
    localparam logic [1:0] OP_JAL  = 2'b10;
    localparam logic [1:0] OP_JALR = 2'b11;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] npc;
    logic [31:0] seq_pc;
    logic [31:0] rel_pc;
    logic [31:0] reg_pc;

    assign seq_pc = pc_q + 32'd4;
    assign rel_pc = pc_q + imm;
    assign reg_pc = rs1 + imm;

    // npc is only consumed on the retiring edge, so the operand inputs are effectively sampled there.
    always_comb begin
        npc = seq_pc;
        case (npc_op)
            OP_SEQ:  npc = seq_pc;
            OP_BR:   npc = br_taken ? rel_pc : seq_pc;
            OP_JAL:  npc = rel_pc;
            OP_JALR: npc = {reg_pc[31:1], 1'b0};
            default: npc = seq_pc;
        endcase
    end

`ifdef MISALIGN_CHK_EN
    logic err_q, err_d;
    logic npc_misaligned;

    assign npc_misaligned = (npc[1:0] != 2'b00);
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
`ifdef MISALIGN_CHK_EN
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                if (imem_ack) begin
                    inst_d  = imem_rdata;
                    state_d = VALID;
                end
            end
            VALID: begin
                if (inst_ready) begin
`ifdef MISALIGN_CHK_EN
                    // A bad target freezes pc at the offending instruction for debug.
                    if (npc_misaligned) begin
                        err_d   = 1'b1;
                        state_d = HALT;
                    end else begin
                        pc_d    = npc;
                        state_d = FETCH;
                    end
`else
                    pc_d    = npc;
                    state_d = FETCH;
`endif
                end
            end
            HALT:    state_d = HALT;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            inst_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
        end
    end

`ifdef MISALIGN_CHK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end

    assign fetch_err = err_q;
`else
    assign fetch_err = 1'b0;
`endif

    // Request and valid are pure state decodes, so reset drops them immediately.
    assign imem_req   = (state_q == FETCH);
    assign imem_addr  = pc_q;
    assign inst_valid = (state_q == VALID);
    assign inst       = inst_q;
    assign pc         = pc_q;
    assign pc4        = seq_pc;

endmodule

// File: tb/tb_ifetch.sv
// Self-checking bench for ifetch: directed scenarios with literal expectations plus randomized traffic
// compared every cycle against a transaction-level model. Define MISALIGN_CHK_EN to exercise the halt path.
module tb_ifetch;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  npc_op = 2'b00;
    logic [31:0] imm = 32'h0;
    logic [31:0] rs1 = 32'h0;
    logic        br_taken = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] inst;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        fetch_err;

    int checks = 0;
    int failures = 0;

    ifetch #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .rst(rst), .npc_op(npc_op), .imm(imm), .rs1(rs1), .br_taken(br_taken),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .inst(inst), .inst_valid(inst_valid), .inst_ready(inst_ready),
        .pc(pc), .pc4(pc4), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- behavioural model ----------------
    logic [31:0] m_pc, m_inst;
    logic        m_started, m_waiting, m_holding, m_halted, m_err;

    function automatic logic [31:0] target(input logic [1:0] op, input logic [31:0] p,
                                           input logic [31:0] im, input logic [31:0] r,
                                           input logic br);
        logic [31:0] t;
        case (op)
            2'd0: t = p + 32'd4;
            2'd1: t = br ? p + im : p + 32'd4;
            2'd2: t = p + im;
            default: t = (r + im) & 32'hFFFF_FFFE;
        endcase
        return t;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pc <= RST_PC; m_inst <= 32'h0;
            m_started <= 1'b0; m_waiting <= 1'b0; m_holding <= 1'b0;
            m_halted <= 1'b0; m_err <= 1'b0;
        end else if (m_halted) begin
            m_halted <= 1'b1;
        end else if (!m_started) begin
            m_started <= 1'b1;
            m_waiting <= 1'b1;
        end else if (m_waiting) begin
            if (imem_ack) begin
                m_inst <= imem_rdata;
                m_waiting <= 1'b0;
                m_holding <= 1'b1;
            end
        end else if (m_holding && inst_ready) begin
            logic [31:0] t;
            t = target(npc_op, m_pc, imm, rs1, br_taken);
            m_holding <= 1'b0;
`ifdef MISALIGN_CHK_EN
            if (t % 4 != 0) begin
                m_err <= 1'b1;
                m_halted <= 1'b1;
            end else begin
                m_pc <= t;
                m_waiting <= 1'b1;
            end
`else
            m_pc <= t;
            m_waiting <= 1'b1;
`endif
        end
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (!rst) begin
            cmp("m_imem_req", {31'h0, imem_req}, {31'h0, m_waiting});
            cmp("m_imem_addr", imem_addr, m_pc);
            cmp("m_pc", pc, m_pc);
            cmp("m_pc4", pc4, m_pc + 32'd4);
            cmp("m_inst_valid", {31'h0, inst_valid}, {31'h0, m_holding});
            cmp("m_fetch_err", {31'h0, fetch_err}, {31'h0, m_err});
            if (m_holding) cmp("m_inst", inst, m_inst);
        end
    end

    // ---------------- directed helpers ----------------
    task automatic do_fetch(input logic [31:0] d);
        int n = 0;
        while (!imem_req && n < 8) begin
            @(negedge clk);
            n++;
        end
        cmp("fetch_req_seen", {31'h0, imem_req}, 32'h1);
        imem_ack = 1'b1;
        imem_rdata = d;
        @(negedge clk);
        imem_ack = 1'b0;
        cmp("fetch_valid", {31'h0, inst_valid}, 32'h1);
        cmp("fetch_inst", inst, d);
    endtask

    task automatic do_retire(input logic [1:0] op, input logic [31:0] im,
                             input logic [31:0] r, input logic br);
        npc_op = op; imm = im; rs1 = r; br_taken = br;
        inst_ready = 1'b1;
        @(negedge clk);
        inst_ready = 1'b0;
        npc_op = 2'($urandom); imm = $urandom; rs1 = $urandom; br_taken = 1'($urandom);
    endtask

    initial begin
        logic [31:0] hold_pc, hold_inst, tmp;

        // Reset state
        repeat (2) @(negedge clk);
        cmp("rst_pc", pc, RST_PC);
        cmp("rst_req", {31'h0, imem_req}, 32'h0);
        cmp("rst_valid", {31'h0, inst_valid}, 32'h0);
        cmp("rst_inst", inst, 32'h0);
        cmp("rst_err", {31'h0, fetch_err}, 32'h0);

        // Release with an immediately available ack
        rst = 1'b0;
        imem_ack = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        cmp("idle_no_req", {31'h0, imem_req}, 32'h0);
        @(negedge clk);
        cmp("c1_req", {31'h0, imem_req}, 32'h1);
        cmp("c1_addr", imem_addr, 32'h0);
        @(negedge clk);
        imem_ack = 1'b0;
        cmp("c2_valid", {31'h0, inst_valid}, 32'h1);
        cmp("c2_inst", inst, 32'hDEAD_BEEF);

        // Branch taken / not taken around pc=0x100
        do_retire(2'd2, 32'h100, 32'h0, 1'b0);
        cmp("jal_addr", imem_addr, 32'h100);
        do_fetch(32'h1111_0001);
        do_retire(2'd1, 32'hFFFF_FFF8, 32'h0, 1'b1);
        cmp("br_taken_addr", imem_addr, 32'hF8);
        do_fetch(32'h1111_0002);
        do_retire(2'd2, 32'h8, 32'h0, 1'b0);
        cmp("back_to_100", imem_addr, 32'h100);
        do_fetch(32'h1111_0003);
        do_retire(2'd1, 32'hFFFF_FFF8, 32'h0, 1'b0);
        cmp("br_not_taken_addr", imem_addr, 32'h104);
        do_fetch(32'h1111_0004);

        // JALR with odd rs1
        cmp("pc4_before_jalr", pc4, 32'h108);
        do_retire(2'd3, 32'h4, 32'h2001, 1'b0);
        cmp("jalr_addr", imem_addr, 32'h2004);
        do_fetch(32'h1111_0005);

        // Stall five cycles with a spurious ack in the middle
        hold_pc = pc;
        hold_inst = inst;
        for (int k = 0; k < 5; k++) begin
            if (k == 2) begin
                imem_ack = 1'b1;
                imem_rdata = 32'hBAD0_BAD0;
            end
            @(negedge clk);
            imem_ack = 1'b0;
            cmp("stall_pc", pc, hold_pc);
            cmp("stall_inst", inst, hold_inst);
            cmp("stall_valid", {31'h0, inst_valid}, 32'h1);
            cmp("stall_req", {31'h0, imem_req}, 32'h0);
        end

        // 32-bit wrap of pc+4
        do_retire(2'd3, 32'h4, 32'hFFFF_FFF8, 1'b0);
        cmp("to_top_addr", imem_addr, 32'hFFFF_FFFC);
        do_fetch(32'h1111_0006);
        do_retire(2'd0, 32'h0, 32'h0, 1'b0);
        cmp("wrap_addr", imem_addr, 32'h0);
        do_fetch(32'h1111_0007);

        // Reset mid-request at pc=0x40, then a late ack in IDLE
        do_retire(2'd2, 32'h40, 32'h0, 1'b0);
        cmp("pre_rst_req", {31'h0, imem_req}, 32'h1);
        cmp("pre_rst_pc", pc, 32'h40);
        #2 rst = 1'b1;
        #1;
        cmp("async_rst_pc", pc, RST_PC);
        cmp("async_rst_req", {31'h0, imem_req}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        imem_ack = 1'b1;
        imem_rdata = 32'h5555_AAAA;
        @(negedge clk);
        imem_ack = 1'b0;
        cmp("late_ack_ignored", {31'h0, inst_valid}, 32'h0);
        cmp("late_ack_req", {31'h0, imem_req}, 32'h1);

`ifndef MISALIGN_CHK_EN
        // Without the checker a misaligned target passes straight through
        do_fetch(32'h1111_0008);
        do_retire(2'd2, 32'h6, 32'h0, 1'b0);
        cmp("misalign_pass_addr", imem_addr, 32'h6);
        cmp("misalign_no_err", {31'h0, fetch_err}, 32'h0);
`endif

        // Randomized traffic, aligned targets, occasional reset
        for (int i = 0; i < 1500; i++) begin
            if (rst) rst = 1'b0;
            else if ($urandom_range(0, 199) == 0) rst = 1'b1;
            imem_ack = imem_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
            imem_rdata = $urandom;
            inst_ready = 1'($urandom);
            npc_op = 2'($urandom);
            tmp = $urandom;
            imm = tmp & 32'hFFFF_FFFC;
            tmp = $urandom;
            rs1 = tmp & 32'hFFFF_FFFD;
            br_taken = 1'($urandom);
            @(negedge clk);
        end
        rst = 1'b0;
        imem_ack = 1'b0;
        inst_ready = 1'b0;

`ifdef MISALIGN_CHK_EN
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_fetch(32'h2222_0001);
        do_retire(2'd2, 32'h10, 32'h0, 1'b0);
        do_fetch(32'h2222_0002);
        do_retire(2'd2, 32'h6, 32'h0, 1'b0);
        cmp("halt_err", {31'h0, fetch_err}, 32'h1);
        cmp("halt_pc", pc, 32'h10);
        cmp("halt_valid", {31'h0, inst_valid}, 32'h0);
        for (int k = 0; k < 4; k++) begin
            imem_ack = 1'b1;
            inst_ready = 1'b1;
            @(negedge clk);
            cmp("halt_no_req", {31'h0, imem_req}, 32'h0);
            cmp("halt_pc_hold", pc, 32'h10);
        end
        imem_ack = 1'b0;
        inst_ready = 1'b0;
`endif

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
